// File: rtl/sdm_tx_pkg.sv
// Shared types for the clocked-to-QDI 1-of-4 transmitter.
// State encoding and watchdog counter width.
package sdm_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        RTZ  = 2'b10
    } tx_state_t;

    localparam int WDOG_W = 16;

endpackage

// File: rtl/sdm_ack_sync.sv
// Purpose: resynchronise the asynchronous QDI ack; primed marks the chain as refilled since reset.
// Latency: STAGES cycles from out_ack to ack_s.
// Backpressure: none, free-running flop chain.
module sdm_ack_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ack,
    output logic ack_s,
    output logic primed
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] fill_q;

    // fill_q walks a 1 through the chain so ack_s is trusted only once it holds real samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], ack};
            fill_q <= {fill_q[STAGES-2:0], 1'b1};
        end
    end

    assign ack_s  = sync_q[STAGES-1];
    assign primed = fill_q[STAGES-1];

endmodule

// File: rtl/sdm_sync_tx.sv
// Purpose: valid/ready word to 4-phase RTZ 1-of-4 QDI channel; rails driven straight from flops. Optional SDM_TX_WDOG_EN watchdog.
// Latency: codeword on the rails one edge after accept; minimum word period 2*SYNC_STAGES+3 cycles.
// Backpressure: in_ready only in IDLE with the synchronised ack low; one word in flight.
module sdm_sync_tx
    import sdm_tx_pkg::*;
#(
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 2,
    parameter int WDOG_LIMIT  = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [DW/2-1:0] out_d0,
    output logic [DW/2-1:0] out_d1,
    output logic [DW/2-1:0] out_d2,
    output logic [DW/2-1:0] out_d3,
    input  logic            out_ack,
    output logic            busy,
    output logic            wdog_err
);

    localparam int NS = DW / 2;

    tx_state_t       state, state_nxt;
    logic            ack_s, primed;
    logic            load, clear;
    logic [NS-1:0]   enc0, enc1, enc2, enc3;

    sdm_ack_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk    (clk),
        .rst    (rst),
        .ack    (out_ack),
        .ack_s  (ack_s),
        .primed (primed)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        load      = 1'b0;
        clear     = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = primed && !ack_s;
                if (in_valid && in_ready) begin
                    load      = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (ack_s) begin
                    clear     = 1'b1;
                    state_nxt = RTZ;
                end
            end
            RTZ: begin
                if (!ack_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        enc0 = '0;
        enc1 = '0;
        enc2 = '0;
        enc3 = '0;
        for (int i = 0; i < NS; i++) begin
            enc0[i] = (in_data[2*i +: 2] == 2'd0);
            enc1[i] = (in_data[2*i +: 2] == 2'd1);
            enc2[i] = (in_data[2*i +: 2] == 2'd2);
            enc3[i] = (in_data[2*i +: 2] == 2'd3);
        end
    end

    // Rails move only on accept (data) or on ack (null), never otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_d0 <= '0;
            out_d1 <= '0;
            out_d2 <= '0;
            out_d3 <= '0;
        end else if (load) begin
            out_d0 <= enc0;
            out_d1 <= enc1;
            out_d2 <= enc2;
            out_d3 <= enc3;
        end else if (clear) begin
            out_d0 <= '0;
            out_d1 <= '0;
            out_d2 <= '0;
            out_d3 <= '0;
        end
    end

`ifdef SDM_TX_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_q;

    // Report only; the handshake is never aborted mid-phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
            wdog_q   <= 1'b0;
        end else begin
            if ((state != state_nxt) || (state == IDLE))
                wdog_cnt <= '0;
            else if (wdog_cnt != WDOG_W'(WDOG_LIMIT))
                wdog_cnt <= wdog_cnt + 1'b1;
            if (wdog_cnt == WDOG_W'(WDOG_LIMIT))
                wdog_q <= 1'b1;
        end
    end

    assign wdog_err = wdog_q;
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_W'(WDOG_LIMIT);
    assign wdog_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sdm_sync_tx.sv
// Directed bench for sdm_sync_tx with an ideal or manually driven QDI receiver.
// Optional SDM_TX_WDOG_EN section exercises the watchdog at a limit of 16.
module tb_sdm_sync_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_d0, out_d1, out_d2, out_d3;
    logic        out_ack;
    logic        busy, wdog_err;

    logic        auto_mode = 1'b0;
    logic        man_ack = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          hot_bad = 0;

    assign out_ack = auto_mode ? (|{out_d0, out_d1, out_d2, out_d3}) : man_ack;

    always #5 clk = ~clk;

    sdm_sync_tx #(.DW(32), .SYNC_STAGES(2), .WDOG_LIMIT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_d0   (out_d0),
        .out_d1   (out_d1),
        .out_d2   (out_d2),
        .out_d3   (out_d3),
        .out_ack  (out_ack),
        .busy     (busy),
        .wdog_err (wdog_err)
    );

    // At most one rail high per symbol, observed away from the clock edge
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                if ((32'(out_d0[i]) + 32'(out_d1[i]) + 32'(out_d2[i]) + 32'(out_d3[i])) > 1)
                    hot_bad = hot_bad + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rails_null();
        return (out_d0 | out_d1 | out_d2 | out_d3) == 16'h0;
    endfunction

    // Ticks until the rails go null then carry a new word; reports both tick counts
    task automatic wait_next_load(output int null_at, output int load_at);
        null_at = 0;
        load_at = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (rails_null() && null_at == 0) null_at = k;
            if (null_at != 0 && !rails_null()) begin
                load_at = k;
                break;
            end
        end
    endtask

    initial begin
        int n_null, n_load, bad, n;

        // reset state
        repeat (3) tick();
        check("rst_rails", {16'h0, out_d0 | out_d1 | out_d2 | out_d3}, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_wdog", wdog_err, 1'b0);
        check("rst_rdy", in_ready, 1'b0);
        rst = 1'b0;
        tick();
        check("rdy_e1", in_ready, 1'b0);
        tick();
        check("rdy_e2", in_ready, 1'b1);

        // 0xE4E4E4E4 with an ideal receiver, then 0 and all-ones back to back
        auto_mode = 1'b1;
        in_data   = 32'hE4E4_E4E4;
        in_valid  = 1'b1;
        tick();
        check("e4_d0", out_d0, 16'h1111);
        check("e4_d1", out_d1, 16'h2222);
        check("e4_d2", out_d2, 16'h4444);
        check("e4_d3", out_d3, 16'h8888);
        check("e4_busy", busy, 1'b1);
        check("e4_rdy", in_ready, 1'b0);
        in_data = 32'h0000_0000;
        wait_next_load(n_null, n_load);
        check("e4_null_at", n_null, 3);
        check("e4_period", n_load, 7);
        check("zero_d0", out_d0, 16'hFFFF);
        check("zero_d123", {16'h0, out_d1 | out_d2 | out_d3}, 32'h0);
        in_data = 32'hFFFF_FFFF;
        wait_next_load(n_null, n_load);
        check("ones_period", n_load, 7);
        check("ones_d3", out_d3, 16'hFFFF);
        check("ones_d012", {16'h0, out_d0 | out_d1 | out_d2}, 32'h0);
        in_valid = 1'b0;
        n = 0;
        while (busy && n < 20) begin tick(); n++; end
        check("drain_busy", busy, 1'b0);

        // reset while in SEND with the receiver holding ack high
        auto_mode = 1'b0;
        man_ack   = 1'b0;
        in_data   = 32'h1234_5678;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        man_ack  = 1'b1;
        tick();
        check("mid_d0", out_d0, 16'hA901);
        check("mid_d1", out_d1, 16'h42E8);
        check("mid_d2", out_d2, 16'h1012);
        check("mid_d3", out_d3, 16'h0404);
        rst = 1'b1;
        #1;
        check("mid_rst_rails", {16'h0, out_d0 | out_d1 | out_d2 | out_d3}, 32'h0);
        check("mid_rst_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (in_ready) bad++;
        end
        check("ack_hi_rdy_low", bad, 0);
        man_ack = 1'b0;
        tick();
        check("ack_drop_e1", in_ready, 1'b0);
        n = 1;
        while (!in_ready && n < 10) begin tick(); n++; end
        check("ack_drop_rdy", in_ready, 1'b1);
        check("ack_drop_lat", (n <= 3), 1'b1);

        // slow receiver: ack held off for 50 cycles
        in_data  = 32'h0000_FFFF;
        in_valid = 1'b1;
        tick();
        in_data = 32'hAAAA_AAAA;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (out_d3 !== 16'h00FF || out_d0 !== 16'hFF00 || (out_d1 | out_d2) !== 16'h0
                || !busy || in_ready)
                bad++;
        end
        check("slow_stable", bad, 0);
        man_ack = 1'b1;
        n = 0;
        while (!rails_null() && n < 10) begin tick(); n++; end
        check("slow_null", rails_null(), 1'b1);
        man_ack = 1'b0;
        n = 0;
        while (rails_null() && n < 10) begin tick(); n++; end
        check("slow_next_d2", out_d2, 16'hFFFF);
        in_valid = 1'b0;
        man_ack  = 1'b1;
        n = 0;
        while (!rails_null() && n < 10) begin tick(); n++; end
        man_ack = 1'b0;
        n = 0;
        while (busy && n < 10) begin tick(); n++; end
        check("slow_idle", busy, 1'b0);

`ifdef SDM_TX_WDOG_EN
        in_data  = 32'hE4E4_E4E4;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        check("wdog_set", wdog_err, 1'b1);
        check("wdog_hold_d3", out_d3, 16'h8888);
        rst = 1'b1;
        #1;
        check("wdog_clear", wdog_err, 1'b0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
`else
        check("wdog_off", wdog_err, 1'b0);
`endif

        check("onehot", hot_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdm_sync_tx.md
# sdm_sync_tx

Clocked-to-QDI transmitter: accepts words from a synchronous valid/ready source and drives them onto a four-phase, return-to-zero, 1-of-4 encoded asynchronous channel with a single acknowledge wire. It sits at the network-interface boundary, where a clocked processing element injects into the asynchronous SDM router input port. The asynchronous ack is resynchronised internally. All channel outputs come straight from flops, so the QDI receiver never sees a glitch or a non-monotonic rail.

## Interface
- DW, 32: payload width in bits; must be even; encoded as DW/2 1-of-4 symbols.
- SYNC_STAGES, 2: flop stages in the ack synchroniser; must be ≥2.
- WDOG_LIMIT, 1024: watchdog threshold in cycles; used only with the watchdog macro.

Ports:
- clk  in  1  the only clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DW  payload word.
- in_valid  in  1  source has a word.
- in_ready  out  1  transmitter accepts `in_data` at this edge.
- out_d0  out  DW/2  rail 0 of each 1-of-4 symbol.
- out_d1  out  DW/2  rail 1 of each symbol.
- out_d2  out  DW/2  rail 2 of each symbol.
- out_d3  out  DW/2  rail 3 of each symbol.
- out_ack  in  1  asynchronous ack from the receiver; high means the word is consumed, low means the channel is ready.
- busy  out  1  a handshake is in progress (state ≠ IDLE).
- wdog_err  out  1  sticky watchdog error; tied 0 when the watchdog is not compiled in.

## Operation
- Encoding: symbol i takes v = in_data[2i+1:2i]. Rail v of symbol i (`out_dv[i]`) is 1; the other three rails of that symbol are 0. Null is all rails 0.
- FSM states:
  - IDLE: rails null; `in_ready` = !ack_s.
  - SEND: rails hold the registered codeword; wait for ack_s = 1.
  - RTZ: rails null; wait for ack_s = 0.
- Transitions:
  - IDLE→SEND on `in_valid` && `in_ready`.
  - SEND→RTZ on ack_s = 1.
  - RTZ→IDLE on ack_s = 0.
- ack_s is `out_ack` after SYNC_STAGES flops.
- Rails are written only on an IDLE→SEND edge (all rails, one-hot per symbol, simultaneously) or a SEND→RTZ edge (all rails to 0). They never change in any other state or at any other edge.
- `in_data` is not registered separately; the rail flops are the only storage. There is no buffering beyond one word in flight.
- Reset, at any time including mid-handshake:
  - State goes to IDLE; all rails go to 0; synchroniser flops go to 0; `busy` = 0; `wdog_err` = 0.
  - After reset, IDLE keeps `in_ready` low until ack_s reads 0. A receiver still holding ack high is therefore never overrun.
- `in_valid` while `in_ready` = 0 is ignored; the source holds the word.

## Timing
- Accept edge E0 → codeword valid on the rails immediately after E0, with one cycle of latency from the handshake.
- With an ideal zero-delay receiver, the minimum word period is 2·SYNC_STAGES+3 cycles (7 at default): E0 load, SEND→RTZ at E0+SYNC_STAGES+1, RTZ→IDLE at E0+2·SYNC_STAGES+2, next accept at E0+2·SYNC_STAGES+3.
- `in_ready` and `busy` are combinational from the state and ack_s flops only; there is no path from `out_ack` to any output.

## Configuration
- `SDM_TX_WDOG_EN` defined:
  - A 16-bit counter clears on every state change and in IDLE.
  - It increments each cycle spent in SEND or RTZ and saturates at WDOG_LIMIT.
  - On reaching WDOG_LIMIT it sets `wdog_err`, which is sticky until `rst`.
  - The FSM is never aborted, because aborting would violate QDI.
- `SDM_TX_WDOG_EN` undefined: no counter; `wdog_err` is constant 0.

## Structure
- Package `sdm_tx_pkg` holds the FSM state encoding (IDLE=2'b00, SEND=2'b01, RTZ=2'b10) and the 16-bit watchdog counter width constant.
- Sub-module `sdm_ack_sync`: a SYNC_STAGES-deep reset-to-0 flop chain for `out_ack`.

## Test plan
- Reset release with `out_ack`=0 and DW=32 → all rails 0, `in_ready`=1 after SYNC_STAGES edges, `busy`=0, `wdog_err`=0.
- Send 0xE4E4E4E4 with a responsive receiver → each byte yields `out_d0..d3` symbols [0,1,2,3], exactly one rail per symbol; null follows ack; next word accepted 7 cycles after the first.
- Back-to-back words 0x00000000 and 0xFFFFFFFF with `in_valid` held high → only `out_d0` all ones, then null, then only `out_d3` all ones; never two rails high in one symbol.
- Assert `rst` while in SEND with ack high → rails null immediately; after release `in_ready` stays 0 until ack drops, then rises SYNC_STAGES+1 edges later.
- Receiver with a 50-cycle ack delay → rails stable throughout; state stays SEND; no word is lost and `in_ready` stays 0.
- `SDM_TX_WDOG_EN`, WDOG_LIMIT=16, ack never returns → `wdog_err`=1 after 16 cycles in SEND, rails still hold the codeword; `rst` clears `wdog_err`.
